regfile_access_arbiter: RTL and testbench

//  Shares the single register-file access port between two requesters: A (core datapath) and B (debug/monitor).

---
 rtl/regfile_access_arbiter.sv | 265 ++++++++++++++++++++++++++
 tb/tb_regfile_access_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_access_arbiter
//
// Shares the single register-file access port between two requesters:
//   A - core datapath
//   B - debug / monitor
// One access takes three cycles (IDLE grant -> ISSUE -> CAPTURE). The winning
// request is latched at the grant edge. The register file is enabled for
// exactly one cycle (ISSUE). Its registered read data is captured into the
// owner's response registers at the end of CAPTURE, and the owner's rvalid
// pulses for one cycle.
//
// Parameters
//   DATA_W     register data width
//   ADDR_W     register address width
//   PRIO_MODE  0 = round-robin between A and B, 1 = fixed priority (A wins)
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   a_*_i / b_*_i                    requester inputs: req, we, raddr1/2, waddr, wdata
//   a_gnt_o / b_gnt_o                request accepted this cycle (IDLE only, combinational)
//   a_rvalid_o / b_rvalid_o          one-cycle response strobe
//   a_rdata1/2_o, b_rdata1/2_o       response data, held until the next own response
//   busy_o                           access in flight (ISSUE or CAPTURE)
//   rf_en_o                          register-file enable, one-cycle pulse in ISSUE
//   rf_reg_write_o                   latched write enable, qualified by ISSUE
//   rf_read_reg1/2_o, rf_write_reg_o latched addresses
//   rf_write_data_o                  latched write data
//   rf_read_data1/2_i                register-file registered read data
// -----------------------------------------------------------------------------
module regfile_access_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,

    // Requester A (core datapath)
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_raddr1_i,
    input  logic [ADDR_W-1:0] a_raddr2_i,
    input  logic [ADDR_W-1:0] a_waddr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic              a_gnt_o,
    output logic              a_rvalid_o,
    output logic [DATA_W-1:0] a_rdata1_o,
    output logic [DATA_W-1:0] a_rdata2_o,

    // Requester B (debug / monitor)
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_raddr1_i,
    input  logic [ADDR_W-1:0] b_raddr2_i,
    input  logic [ADDR_W-1:0] b_waddr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              b_gnt_o,
    output logic              b_rvalid_o,
    output logic [DATA_W-1:0] b_rdata1_o,
    output logic [DATA_W-1:0] b_rdata2_o,

    // Status
    output logic              busy_o,

    // Register-file port
    output logic              rf_en_o,
    output logic              rf_reg_write_o,
    output logic [ADDR_W-1:0] rf_read_reg1_o,
    output logic [ADDR_W-1:0] rf_read_reg2_o,
    output logic [ADDR_W-1:0] rf_write_reg_o,
    output logic [DATA_W-1:0] rf_write_data_o,
    input  logic [DATA_W-1:0] rf_read_data1_i,
    input  logic [DATA_W-1:0] rf_read_data2_i
);

    // Owner encoding, also used as the index of the response generate block.
    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] raddr1_q, raddr1_d;
    logic [ADDR_W-1:0] raddr2_q, raddr2_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              grant_valid;
    logic              grant_owner;

    // Fields of the winning requester, selected by grant_owner.
    logic              sel_we;
    logic [ADDR_W-1:0] sel_raddr1;
    logic [ADDR_W-1:0] sel_raddr2;
    logic [ADDR_W-1:0] sel_waddr;
    logic [DATA_W-1:0] sel_wdata;

    // -------------------------------------------------------------------------
    // Arbitration. Only evaluated in IDLE, so a request raised during an
    // access simply stays pending until the FSM is back in IDLE.
    // On a tie, round-robin hands the port to whoever did not win last;
    // last_owner resets to B so A wins the first tie.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_valid = 1'b0;
        grant_owner = OWNER_A;
        if (state_q == ST_IDLE) begin
            if (a_req_i && b_req_i) begin
                grant_valid = 1'b1;
                if (PRIO_MODE == 1) begin
                    grant_owner = OWNER_A;
                end else begin
                    grant_owner = ~last_owner_q;
                end
            end else if (a_req_i) begin
                grant_valid = 1'b1;
                grant_owner = OWNER_A;
            end else if (b_req_i) begin
                grant_valid = 1'b1;
                grant_owner = OWNER_B;
            end
        end
    end

    assign a_gnt_o = grant_valid && (grant_owner == OWNER_A);
    assign b_gnt_o = grant_valid && (grant_owner == OWNER_B);

    always_comb begin
        if (grant_owner == OWNER_B) begin
            sel_we     = b_we_i;
            sel_raddr1 = b_raddr1_i;
            sel_raddr2 = b_raddr2_i;
            sel_waddr  = b_waddr_i;
            sel_wdata  = b_wdata_i;
        end else begin
            sel_we     = a_we_i;
            sel_raddr1 = a_raddr1_i;
            sel_raddr2 = a_raddr2_i;
            sel_waddr  = a_waddr_i;
            sel_wdata  = a_wdata_i;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and request latch. The latched fields only change at a
    // grant edge, so the rf_* address/data outputs keep their values between
    // accesses.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        raddr1_d     = raddr1_q;
        raddr2_d     = raddr2_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d      = ST_ISSUE;
                    owner_d      = grant_owner;
                    last_owner_d = grant_owner;
                    we_d         = sel_we;
                    raddr1_d     = sel_raddr1;
                    raddr2_d     = sel_raddr2;
                    waddr_d      = sel_waddr;
                    wdata_d      = sel_wdata;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_B;
            last_owner_q <= OWNER_B;
            we_q         <= 1'b0;
            raddr1_q     <= '0;
            raddr2_q     <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            raddr1_q     <= raddr1_d;
            raddr2_q     <= raddr2_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Register-file drive. rf_en and the write strobe are decoded from the
    // state register, so an asynchronous reset during ISSUE removes them
    // immediately and the pending write never reaches the register file.
    // Write address 0 is passed through untouched.
    // -------------------------------------------------------------------------
    assign rf_en_o         = (state_q == ST_ISSUE);
    assign rf_reg_write_o  = (state_q == ST_ISSUE) && we_q;
    assign rf_read_reg1_o  = raddr1_q;
    assign rf_read_reg2_o  = raddr2_q;
    assign rf_write_reg_o  = waddr_q;
    assign rf_write_data_o = wdata_q;
    assign busy_o          = (state_q == ST_ISSUE) || (state_q == ST_CAPTURE);

    // -------------------------------------------------------------------------
    // Per-requester response registers. Index 0 is A, index 1 is B. Each block
    // only reacts when its requester owns the access in CAPTURE, so the other
    // requester's rdata and rvalid are left alone.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : gen_resp
        localparam logic MY_ID = 1'(gi);

        logic              capture_hit;
        logic              rvalid_q;
        logic [DATA_W-1:0] rdata1_q;
        logic [DATA_W-1:0] rdata2_q;

        assign capture_hit = (state_q == ST_CAPTURE) && (owner_q == MY_ID);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rvalid_q <= 1'b0;
                rdata1_q <= '0;
                rdata2_q <= '0;
            end else begin
                rvalid_q <= capture_hit;
                if (capture_hit) begin
                    rdata1_q <= rf_read_data1_i;
                    rdata2_q <= rf_read_data2_i;
                end
            end
        end
    end

    assign a_rvalid_o = gen_resp[0].rvalid_q;
    assign a_rdata1_o = gen_resp[0].rdata1_q;
    assign a_rdata2_o = gen_resp[0].rdata2_q;
    assign b_rvalid_o = gen_resp[1].rvalid_q;
    assign b_rdata1_o = gen_resp[1].rdata1_q;
    assign b_rdata2_o = gen_resp[1].rdata2_q;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_access_arbiter
//
// Two arbiter instances: dut (round-robin) attached to a small behavioural
// register file, and dut_fp (fixed priority) used for the priority sequence.
// Accesses come from a table of {request, expected read data} records; the
// expectation is queued when the grant is seen and compared when the owner's
// rvalid arrives, including the owner identity and the gnt->rvalid latency.
// -----------------------------------------------------------------------------
module tb_regfile_access_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;

    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_raddr1, a_raddr2, a_waddr, b_raddr1, b_raddr2, b_waddr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, busy;
    logic [DW-1:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
    logic          rf_en, rf_reg_write;
    logic [AW-1:0] rf_read_reg1, rf_read_reg2, rf_write_reg;
    logic [DW-1:0] rf_write_data, rf_rd1, rf_rd2;

    // Fixed-priority instance signals
    logic          fa_req, fb_req;
    logic          fp_a_gnt, fp_b_gnt, fp_a_rvalid, fp_b_rvalid, fp_busy;
    logic [DW-1:0] fp_a_rdata1, fp_a_rdata2, fp_b_rdata1, fp_b_rdata2;
    logic          fp_rf_en, fp_rf_reg_write;
    logic [AW-1:0] fp_rf_read_reg1, fp_rf_read_reg2, fp_rf_write_reg;
    logic [DW-1:0] fp_rf_write_data;
    logic [DW-1:0] zero_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_access_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PRIO_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_i(a_req), .a_we_i(a_we), .a_raddr1_i(a_raddr1), .a_raddr2_i(a_raddr2),
        .a_waddr_i(a_waddr), .a_wdata_i(a_wdata), .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid),
        .a_rdata1_o(a_rdata1), .a_rdata2_o(a_rdata2),
        .b_req_i(b_req), .b_we_i(b_we), .b_raddr1_i(b_raddr1), .b_raddr2_i(b_raddr2),
        .b_waddr_i(b_waddr), .b_wdata_i(b_wdata), .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid),
        .b_rdata1_o(b_rdata1), .b_rdata2_o(b_rdata2),
        .busy_o(busy), .rf_en_o(rf_en), .rf_reg_write_o(rf_reg_write),
        .rf_read_reg1_o(rf_read_reg1), .rf_read_reg2_o(rf_read_reg2),
        .rf_write_reg_o(rf_write_reg), .rf_write_data_o(rf_write_data),
        .rf_read_data1_i(rf_rd1), .rf_read_data2_i(rf_rd2)
    );

    regfile_access_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PRIO_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .a_req_i(fa_req), .a_we_i(a_we), .a_raddr1_i(a_raddr1), .a_raddr2_i(a_raddr2),
        .a_waddr_i(a_waddr), .a_wdata_i(a_wdata), .a_gnt_o(fp_a_gnt), .a_rvalid_o(fp_a_rvalid),
        .a_rdata1_o(fp_a_rdata1), .a_rdata2_o(fp_a_rdata2),
        .b_req_i(fb_req), .b_we_i(b_we), .b_raddr1_i(b_raddr1), .b_raddr2_i(b_raddr2),
        .b_waddr_i(b_waddr), .b_wdata_i(b_wdata), .b_gnt_o(fp_b_gnt), .b_rvalid_o(fp_b_rvalid),
        .b_rdata1_o(fp_b_rdata1), .b_rdata2_o(fp_b_rdata2),
        .busy_o(fp_busy), .rf_en_o(fp_rf_en), .rf_reg_write_o(fp_rf_reg_write),
        .rf_read_reg1_o(fp_rf_read_reg1), .rf_read_reg2_o(fp_rf_read_reg2),
        .rf_write_reg_o(fp_rf_write_reg), .rf_write_data_o(fp_rf_write_data),
        .rf_read_data1_i(zero_data), .rf_read_data2_i(zero_data)
    );

    // Behavioural register file: registered reads, read-before-write, r0 ignores writes.
    logic [DW-1:0] rf_mem [32];
    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
        rf_rd1 = '0;
        rf_rd2 = '0;
    end
    always @(posedge clk) begin
        if (rf_en) begin
            rf_rd1 <= rf_mem[rf_read_reg1];
            rf_rd2 <= rf_mem[rf_read_reg2];
            if (rf_reg_write && (rf_write_reg != '0)) rf_mem[rf_write_reg] <= rf_write_data;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------ vector table
    typedef struct {
        bit            who;    // 0 = A, 1 = B
        bit            we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input bit who, input bit we, input int waddr, input logic [DW-1:0] wdata,
                                input int ra1, input int ra2, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        vec_t v;
        v.who = who; v.we = we; v.waddr = AW'(waddr); v.wdata = wdata;
        v.ra1 = AW'(ra1); v.ra2 = AW'(ra2); v.exp1 = e1; v.exp2 = e2;
        return v;
    endfunction

    // ------------------------------------------------------------ scoreboard
    typedef struct {
        bit            who;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        int            due;
        int            idx;
    } exp_t;

    exp_t sb [$];
    bit   glog_who [$];
    int   glog_cyc [$];

    task automatic push_exp(input int idx);
        exp_t e;
        e.who = vecs[idx].who; e.d1 = vecs[idx].exp1; e.d2 = vecs[idx].exp2;
        e.due = cyc + 3; e.idx = idx;
        sb.push_back(e);
        glog_who.push_back(vecs[idx].who);
        glog_cyc.push_back(cyc);
    endtask

    task automatic resp_check(input bit who, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        exp_t e;
        if (sb.size() == 0) begin
            check($sformatf("unexpected_rvalid_%0d", who), 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            $display("resp vec=%0d who=%0d rdata1=%08h rdata2=%08h cyc=%0d", e.idx, who, d1, d2, cyc);
            check($sformatf("v%0d_owner", e.idx), 64'(who), 64'(e.who));
            check($sformatf("v%0d_latency", e.idx), 64'(cyc), 64'(e.due));
            check($sformatf("v%0d_rdata1", e.idx), 64'(d1), 64'(e.d1));
            check($sformatf("v%0d_rdata2", e.idx), 64'(d2), 64'(e.d2));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_rvalid) resp_check(1'b0, a_rdata1, a_rdata2);
            if (b_rvalid) resp_check(1'b1, b_rdata1, b_rdata2);
        end
    end

    // ------------------------------------------------------------ drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fields(input int idx);
        if (vecs[idx].who == 1'b0) begin
            a_we = vecs[idx].we; a_waddr = vecs[idx].waddr; a_wdata = vecs[idx].wdata;
            a_raddr1 = vecs[idx].ra1; a_raddr2 = vecs[idx].ra2;
        end else begin
            b_we = vecs[idx].we; b_waddr = vecs[idx].waddr; b_wdata = vecs[idx].wdata;
            b_raddr1 = vecs[idx].ra1; b_raddr2 = vecs[idx].ra2;
        end
    endtask

    task automatic set_req(input bit who, input logic v);
        if (who == 1'b0) a_req = v; else b_req = v;
    endtask

    // Raise the request, wait (bounded) for its grant, queue the expectation.
    task automatic run_access(input int idx);
        bit who;
        bit got;
        who = vecs[idx].who;
        got = 1'b0;
        drive_fields(idx);
        set_req(who, 1'b1);
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if ((who == 1'b0) ? a_gnt : b_gnt) got = 1'b1;
        end
        check($sformatf("v%0d_gnt_seen", idx), 64'(got), 64'd1);
        if (got) push_exp(idx);
        tick();
        set_req(who, 1'b0);
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ main test
    initial begin
        vecs[0]  = mk(0, 1,  5, 32'hDEADBEEF,  5,  0, 32'h0,        32'h0);
        vecs[1]  = mk(0, 0,  0, 32'h0,         5,  5, 32'hDEADBEEF, 32'hDEADBEEF);
        vecs[2]  = mk(1, 1,  0, 32'h00001234,  0,  5, 32'h0,        32'hDEADBEEF);
        vecs[3]  = mk(1, 0,  0, 32'h0,         0,  0, 32'h0,        32'h0);
        vecs[4]  = mk(0, 1, 10, 32'hA0A00001,  5, 10, 32'hDEADBEEF, 32'h0);
        vecs[5]  = mk(0, 1, 11, 32'hA0A00002, 10, 11, 32'hA0A00001, 32'h0);
        vecs[6]  = mk(1, 1, 20, 32'hB0B00001, 20,  5, 32'h0,        32'hDEADBEEF);
        vecs[7]  = mk(1, 0,  0, 32'h0,        20, 11, 32'hB0B00001, 32'hA0A00002);
        vecs[8]  = mk(0, 1, 12, 32'hC0DE0012, 12, 20, 32'h0,        32'hB0B00001);
        vecs[9]  = mk(1, 0,  0, 32'h0,        12, 10, 32'hC0DE0012, 32'hA0A00001);
        vecs[10] = mk(0, 0,  0, 32'h0,         7,  5, 32'h0,        32'hDEADBEEF);
        vecs[11] = mk(1, 0,  0, 32'h0,         7, 12, 32'h0,        32'hC0DE0012);

        zero_data = '0;
        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_raddr1 = '0; a_raddr2 = '0; a_waddr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_raddr1 = '0; b_raddr2 = '0; b_waddr = '0; b_wdata = '0;
        fa_req = 0; fb_req = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_gnt", 64'(a_gnt), 64'd0);
        check("rst_b_gnt", 64'(b_gnt), 64'd0);
        check("rst_rvalid", 64'({a_rvalid, b_rvalid}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rf_en", 64'({rf_en, rf_reg_write}), 64'd0);
        check("rst_rf_addr", 64'({rf_read_reg1, rf_read_reg2, rf_write_reg}), 64'd0);
        check("rst_rf_wdata", 64'(rf_write_data), 64'd0);
        check("rst_rdata", 64'(a_rdata1 | a_rdata2 | b_rdata1 | b_rdata2), 64'd0);
        check("rst_fp_busy", 64'(fp_busy), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single A write with per-cycle timing
        drive_fields(0);
        a_req = 1'b1;
        @(negedge clk);
        $display("t1 A write r5 grant cyc=%0d", cyc);
        check("t1_a_gnt_T", 64'(a_gnt), 64'd1);
        check("t1_rf_en_T", 64'(rf_en), 64'd0);
        push_exp(0);
        tick();
        a_req = 1'b0;
        @(negedge clk);
        check("t1_rf_en_T1", 64'(rf_en), 64'd1);
        check("t1_rf_we_T1", 64'(rf_reg_write), 64'd1);
        check("t1_rf_wreg", 64'(rf_write_reg), 64'd5);
        check("t1_rf_wdata", 64'(rf_write_data), 64'hDEADBEEF);
        check("t1_rf_rreg1", 64'(rf_read_reg1), 64'd5);
        check("t1_busy_T1", 64'(busy), 64'd1);
        tick();
        @(negedge clk);
        check("t1_rf_en_T2", 64'({rf_en, rf_reg_write}), 64'd0);
        check("t1_busy_T2", 64'(busy), 64'd1);
        check("t1_rvalid_T2", 64'(a_rvalid), 64'd0);
        check("t1_wreg_hold", 64'(rf_write_reg), 64'd5);
        tick();
        @(negedge clk);
        check("t1_rvalid_T3", 64'(a_rvalid), 64'd1);
        check("t1_busy_T3", 64'(busy), 64'd0);
        tick();
        @(negedge clk);
        check("t1_rvalid_T4", 64'(a_rvalid), 64'd0);
        tick();

        // Table loop: read back r5, write/read r0
        for (int i = 1; i <= 3; i++) begin
            $display("vec %0d who=%0d we=%0d", i, vecs[i].who, vecs[i].we);
            run_access(i);
        end
        drain();

        // Round-robin with both requesters held
        glog_who.delete();
        glog_cyc.delete();
        fork
            begin run_access(4); run_access(5); end
            begin run_access(6); run_access(7); end
        join
        drain();
        check("rr_grants", 64'(glog_who.size()), 64'd4);
        if (glog_who.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                $display("rr grant %0d who=%0d cyc=%0d", i, glog_who[i], glog_cyc[i]);
                check($sformatf("rr_order_%0d", i), 64'(glog_who[i]), 64'(i % 2));
                if (i > 0) check($sformatf("rr_gap_%0d", i), 64'(glog_cyc[i] - glog_cyc[i-1]), 64'd3);
            end
        end

        // Pending request raised during ISSUE
        glog_who.delete();
        glog_cyc.delete();
        drive_fields(8);
        a_req = 1'b1;
        @(negedge clk);
        check("t4_a_gnt", 64'(a_gnt), 64'd1);
        push_exp(8);
        tick();
        a_req = 1'b0;
        drive_fields(9);
        b_req = 1'b1;
        @(negedge clk);
        check("t4_b_gnt_issue", 64'(b_gnt), 64'd0);
        tick();
        @(negedge clk);
        check("t4_b_gnt_capture", 64'(b_gnt), 64'd0);
        tick();
        @(negedge clk);
        $display("t4 pending B cyc=%0d b_gnt=%0d a_rvalid=%0d", cyc, b_gnt, a_rvalid);
        check("t4_b_gnt_T3", 64'(b_gnt), 64'd1);
        check("t4_a_rvalid_T3", 64'(a_rvalid), 64'd1);
        check("t4_b_rdata1_held", 64'(b_rdata1), 64'hB0B00001);
        if (b_gnt) push_exp(9);
        tick();
        b_req = 1'b0;
        drain();

        // Reset during ISSUE of a write r7 = 0x55
        a_we = 1'b1; a_waddr = 5'd7; a_wdata = 32'h55; a_raddr1 = 5'd7; a_raddr2 = 5'd0;
        a_req = 1'b1;
        @(negedge clk);
        check("t6_a_gnt", 64'(a_gnt), 64'd1);
        tick();
        a_req = 1'b0;
        @(negedge clk);
        check("t6_rf_en_issue", 64'(rf_en), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("t6 reset in ISSUE rf_en=%0d busy=%0d", rf_en, busy);
        check("t6_rf_en_drop", 64'({rf_en, rf_reg_write}), 64'd0);
        check("t6_busy_drop", 64'(busy), 64'd0);
        check("t6_a_rdata2_rst", 64'(a_rdata2), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t6_no_rvalid_%0d", k), 64'({a_rvalid, b_rvalid}), 64'd0);
        end
        tick();
        glog_who.delete();
        glog_cyc.delete();
        fork
            run_access(10);
            run_access(11);
        join
        drain();
        check("t6_tie_grants", 64'(glog_who.size()), 64'd2);
        if (glog_who.size() == 2) begin
            check("t6_tie_first_A", 64'(glog_who[0]), 64'd0);
            check("t6_tie_second_B", 64'(glog_who[1]), 64'd1);
        end

        // Fixed priority: both held, A wins every 3 cycles
        fa_req = 1'b1;
        fb_req = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            $display("fp cycle %0d a_gnt=%0d b_gnt=%0d", n, fp_a_gnt, fp_b_gnt);
            check($sformatf("fp_a_gnt_%0d", n), 64'(fp_a_gnt), 64'(n % 3 == 0));
            check($sformatf("fp_b_gnt_%0d", n), 64'(fp_b_gnt), 64'd0);
            tick();
        end
        fa_req = 1'b0;
        @(negedge clk);
        check("fp_b_gnt_after_a_drop", 64'(fp_b_gnt), 64'd1);
        tick();
        fb_req = 1'b0;
        repeat (4) tick();

        check("sb_final_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
